rds_encoder: RTL

//  RDS group-0A baseband source feeding fmgen alongside the tone path. Builds 104-bit groups (PI, PTY/TP/TA/MS/DI,
//  AF, 2 PS chars) with 10-bit CRC+offset checkwords, differentially encodes them and emits the biphase symbol

---
 rtl/rds_encoder.sv | 127 ++++++++++++
 1 files changed

// File: rtl/rds_encoder.sv
// rds_encoder: RDS group-0A builder (CRC checkwords, shadow/shift registers) with differential
// biphase symbol output at the half-bit rate of a 24-bit NCO.
module rds_encoder #(
  parameter logic [23:0] HALFBIT_INC = 24'd1594,
  parameter logic [15:0] AF_WORD     = 16'hCDCD,
  parameter logic [3:0]  DI          = 4'b0001
) (
  input  logic        clk_25m,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [15:0] pi,
  input  logic [4:0]  pty,
  input  logic        tp,
  input  logic        ta,
  input  logic        ms,
  input  logic [63:0] ps_name,
  output logic        rds_sym,
  output logic        sym_strobe,
  output logic        bit_strobe,
  output logic        data_bit,
  output logic        group_start,
  output logic [1:0]  segment
);
  typedef enum logic [1:0] {IDLE, LATCH, CRC, READY} state_t;
  state_t state, state_nx;
  logic [23:0] acc;
  logic [24:0] acc_sum;
  logic carry, first_half, load, bit_val, fb, odd, d_prev, run;
  logic [6:0] bit_idx;
  logic [1:0] c, shadow_seg;
  logic [103:0] shadow, shift;
  logic [63:0] info;
  logic [14:0] blk;
  logic [9:0] crc, crc_nx, offset;
  logic [5:0] cnt;
  assign acc_sum = {1'b0, acc} + {1'b0, HALFBIT_INC};
  assign carry = acc_sum[24] & run;
  assign first_half = carry & ~odd;
  assign load = first_half && bit_idx == 7'd0;
  assign bit_val = load ? shadow[103] : shift[103];
  assign fb = info[63] ^ crc[9];
  assign crc_nx = {crc[8:0], 1'b0} ^ (fb ? 10'h1B9 : 10'h000);
  assign offset = cnt[5:4] == 2'd0 ? 10'h0FC : cnt[5:4] == 2'd1 ? 10'h198 :
                  cnt[5:4] == 2'd2 ? 10'h168 : 10'h1B4;
  always_comb begin
    state_nx = state;
    if (!enable) state_nx = IDLE;
    else if (state == IDLE) state_nx = LATCH;
    else if (state == LATCH) state_nx = CRC;
    else if (state == CRC && cnt == 6'd63) state_nx = READY;
    else if (state == READY && load) state_nx = LATCH;
  end
  // The NCO is held until the first shadow group is ready, so the first carry always has data.
  always_ff @(posedge clk_25m or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      acc <= '0;
      run <= 1'b0;
      odd <= 1'b0;
      d_prev <= 1'b0;
      bit_idx <= '0;
      c <= '0;
      segment <= '0;
      shadow_seg <= '0;
      rds_sym <= 1'b0;
      sym_strobe <= 1'b0;
      bit_strobe <= 1'b0;
      data_bit <= 1'b0;
      group_start <= 1'b0;
      shadow <= '0;
      shift <= '0;
      info <= '0;
      blk <= '0;
      crc <= '0;
      cnt <= '0;
    end else if (!enable) begin
      state <= IDLE;
      acc <= '0;
      run <= 1'b0;
      odd <= 1'b0;
      d_prev <= 1'b0;
      bit_idx <= '0;
      c <= '0;
      segment <= '0;
      rds_sym <= 1'b0;
      sym_strobe <= 1'b0;
      bit_strobe <= 1'b0;
      data_bit <= 1'b0;
      group_start <= 1'b0;
    end else begin
      state <= state_nx;
      run <= run | (state == READY);
      acc <= run ? acc_sum[23:0] : acc;
      sym_strobe <= carry;
      bit_strobe <= first_half;
      group_start <= load;
      if (carry) odd <= ~odd;
      if (first_half) begin
        data_bit <= bit_val;
        rds_sym <= bit_val ^ d_prev;
        d_prev <= bit_val ^ d_prev;
        shift <= load ? {shadow[102:0], 1'b0} : {shift[102:0], 1'b0};
        bit_idx <= bit_idx == 7'd103 ? 7'd0 : bit_idx + 7'd1;
      end else if (carry) begin
        rds_sym <= ~d_prev;
      end
      if (load) begin
        segment <= shadow_seg;
        c <= c + 2'd1;
      end
      if (state == LATCH) begin
        info <= {pi, 5'b00000, tp, pty, ta, ms, DI[~c], c, AF_WORD, ps_name[{~c, 4'hF} -: 16]};
        shadow_seg <= c;
        cnt <= '0;
        crc <= '0;
      end
      // Each 16th CRC clock closes a block: info word plus checkword shift into the shadow.
      if (state == CRC) begin
        info <= {info[62:0], 1'b0};
        blk <= {blk[13:0], info[63]};
        cnt <= cnt + 6'd1;
        crc <= cnt[3:0] == 4'hF ? 10'h000 : crc_nx;
        if (cnt[3:0] == 4'hF) shadow <= {shadow[77:0], blk, info[63], crc_nx ^ offset};
      end
    end
  end
endmodule
